// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap sequencer: CSR addresses,
// exception codes, mcause values, mstatus bit positions and FSM encoding.
package trap_ctrl_pkg;

  // CSR addresses
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  // Decoded exception code as delivered by the decoder
  typedef enum logic [1:0] {
    EXC_NONE    = 2'b00,
    EXC_ILLEGAL = 2'b01,
    EXC_ECALL   = 2'b10,
    EXC_EBREAK  = 2'b11
  } exc_e;

  // mcause values
  localparam logic [31:0] MCAUSE_ILLEGAL = 32'd2;
  localparam logic [31:0] MCAUSE_EBREAK  = 32'd3;
  localparam logic [31:0] MCAUSE_ECALL   = 32'd11;
  localparam logic [31:0] MCAUSE_EXT_IRQ = 32'h8000_000B;

  // mstatus bit positions
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  // FSM encoding
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_TRAP    = 3'd1;
  localparam logic [2:0] ST_RET     = 3'd2;
  localparam logic [2:0] ST_REDIR_T = 3'd3;
  localparam logic [2:0] ST_REDIR_R = 3'd4;

  // Map a synchronous exception onto its mcause value
  function automatic logic [31:0] exc_cause(input exc_e exc);
    case (exc)
      EXC_ILLEGAL: return MCAUSE_ILLEGAL;
      EXC_ECALL:   return MCAUSE_ECALL;
      EXC_EBREAK:  return MCAUSE_EBREAK;
      default:     return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/trap_ctrl_sync_ff.sv
// Flop chain synchroniser for a single asynchronous level signal.
// DEPTH sets the number of stages (2..4 in practice).
module trap_ctrl_sync_ff #(
  parameter int DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] chain;

  // Shift the asynchronous input through the chain
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      chain <= '0;
    end else begin
      // NOTE: non-blocking so each stage takes its neighbour's pre-edge value.
      chain <= {chain[DEPTH-2:0], d_i};
    end
  end

  assign q_o = chain[DEPTH-1];

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer in EX. Takes exceptions, mret and an external
// interrupt, owns mepc/mcause/mstatus(MIE,MPIE)/mtvec, and turns each event
// into a one-cycle stall followed by a one-cycle redirect pulse.
// Optional: define TRAP_CTRL_MTVAL_EN to add the mtval CSR at 0x343.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET     = 32'h0000_0100,
  parameter int          IRQ_SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [31:0] pc_i,
  input  logic [1:0]  exception_i,
  input  logic        is_mret_i,
  input  logic [31:0] instr_i,
  input  logic        irq_i,
  input  logic        csr_we_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_wdata_i,
  output logic [31:0] csr_rdata_o,
  output logic        stall_o,
  output logic        redirect_o,
  output logic [31:0] target_pc_o,
  output logic [31:0] mepc_o,
  output logic        mie_o
);

  logic [2:0]  state_q, state_d;
  logic [31:0] mepc_q, mcause_q, mtvec_q, mtval_rd;
  logic        mie_q, mpie_q;
  logic        irq_s;
  exc_e        exc;
  logic        take_exc, take_irq, take_trap, take_ret;

  trap_ctrl_sync_ff #(.DEPTH(IRQ_SYNC_STAGES)) u_irq_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (irq_i),
    .q_o   (irq_s)
  );

  assign exc = exc_e'(exception_i);

  // Event selection, only in IDLE with a valid instruction:
  // exception beats interrupt beats mret
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    take_exc  = 1'b0;
    take_irq  = 1'b0;
    take_trap = 1'b0;
    take_ret  = 1'b0;
    if (state_q == ST_IDLE && valid_i) begin
      take_exc  = (exc != EXC_NONE);
      take_irq  = !take_exc && irq_s && mie_q;
      take_trap = take_exc || take_irq;
      take_ret  = !take_trap && is_mret_i;
    end
  end

  // Next-state logic: event -> stall -> redirect -> IDLE
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: begin
        if (take_trap)     state_d = ST_TRAP;
        else if (take_ret) state_d = ST_RET;
        else               state_d = ST_IDLE;
      end
      ST_TRAP:    state_d = ST_REDIR_T;
      ST_RET:     state_d = ST_REDIR_R;
      ST_REDIR_T: state_d = ST_IDLE;
      ST_REDIR_R: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // CSR registers; the trap/mret update is written after the CSR write so
  // it overrides the fields it touches, while mtvec writes always land
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mepc_q   <= '0;
      mcause_q <= '0;
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
      mtvec_q  <= {MTVEC_RESET[31:2], 2'b00};
    end else begin
      if (csr_we_i) begin
        case (csr_addr_i)
          CSR_MSTATUS: begin
            mie_q  <= csr_wdata_i[MSTATUS_MIE];
            mpie_q <= csr_wdata_i[MSTATUS_MPIE];
          end
          CSR_MTVEC:  mtvec_q  <= {csr_wdata_i[31:2], 2'b00};
          CSR_MEPC:   mepc_q   <= {csr_wdata_i[31:2], 2'b00};
          CSR_MCAUSE: mcause_q <= csr_wdata_i;
          default: ;
        endcase
      end
      if (take_trap) begin
        mepc_q   <= pc_i;
        mcause_q <= take_exc ? exc_cause(exc) : MCAUSE_EXT_IRQ;
        mpie_q   <= mie_q;
        mie_q    <= 1'b0;
      end else if (take_ret) begin
        mie_q  <= mpie_q;
        mpie_q <= 1'b1;
      end
    end
  end

`ifdef TRAP_CTRL_MTVAL_EN
  logic [31:0] mtval_q;

  // mtval: faulting instruction bits on illegal, zero on any other trap
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mtval_q <= '0;
    end else if (take_trap) begin
      mtval_q <= (take_exc && exc == EXC_ILLEGAL) ? instr_i : 32'd0;
    end else if (csr_we_i && csr_addr_i == CSR_MTVAL) begin
      mtval_q <= csr_wdata_i;
    end
  end

  assign mtval_rd = mtval_q;
`else
  logic unused_instr;
  assign unused_instr = ^instr_i;
  assign mtval_rd     = 32'd0;
`endif

  // Combinational CSR read of pre-edge register values
  always_comb begin
    csr_rdata_o = '0;
    case (csr_addr_i)
      CSR_MSTATUS: begin
        csr_rdata_o[MSTATUS_MIE]  = mie_q;
        csr_rdata_o[MSTATUS_MPIE] = mpie_q;
      end
      CSR_MTVEC:  csr_rdata_o = {mtvec_q[31:2], 2'b00};
      CSR_MEPC:   csr_rdata_o = mepc_q;
      CSR_MCAUSE: csr_rdata_o = mcause_q;
      CSR_MTVAL:  csr_rdata_o = mtval_rd;
      default:    csr_rdata_o = '0;
    endcase
  end

  // Pipeline control decoded from registered state only
  always_comb begin
    stall_o     = 1'b0;
    redirect_o  = 1'b0;
    target_pc_o = '0;
    case (state_q)
      ST_TRAP, ST_RET: stall_o = 1'b1;
      ST_REDIR_T: begin
        redirect_o  = 1'b1;
        target_pc_o = {mtvec_q[31:2], 2'b00};
      end
      ST_REDIR_R: begin
        redirect_o  = 1'b1;
        target_pc_o = mepc_q;
      end
      default: ;
    endcase
  end

  assign mepc_o = mepc_q;
  assign mie_o  = mie_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: expected redirect targets are queued when an
// event is driven and popped when the redirect pulse appears.
module tb_trap_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [31:0] pc_i;
  logic [1:0]  exception_i;
  logic        is_mret_i;
  logic [31:0] instr_i;
  logic        irq_i;
  logic        csr_we_i;
  logic [11:0] csr_addr_i;
  logic [31:0] csr_wdata_i;
  logic [31:0] csr_rdata_o;
  logic        stall_o;
  logic        redirect_o;
  logic [31:0] target_pc_o;
  logic [31:0] mepc_o;
  logic        mie_o;

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] sb[$];

  trap_ctrl #(
    .MTVEC_RESET     (32'h0000_0100),
    .IRQ_SYNC_STAGES (2)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .valid_i     (valid_i),
    .pc_i        (pc_i),
    .exception_i (exception_i),
    .is_mret_i   (is_mret_i),
    .instr_i     (instr_i),
    .irq_i       (irq_i),
    .csr_we_i    (csr_we_i),
    .csr_addr_i  (csr_addr_i),
    .csr_wdata_i (csr_wdata_i),
    .csr_rdata_o (csr_rdata_o),
    .stall_o     (stall_o),
    .redirect_o  (redirect_o),
    .target_pc_o (target_pc_o),
    .mepc_o      (mepc_o),
    .mie_o       (mie_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    valid_i     = 1'b0;
    exception_i = 2'b00;
    is_mret_i   = 1'b0;
    csr_we_i    = 1'b0;
  endtask

  task automatic read_csr(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    csr_addr_i = addr;
    #1;
    check(tag, csr_rdata_o, exp);
  endtask

  task automatic write_csr(input logic [11:0] addr, input logic [31:0] data);
    csr_we_i    = 1'b1;
    csr_addr_i  = addr;
    csr_wdata_i = data;
    step();
    csr_we_i    = 1'b0;
  endtask

  // Called in the cycle after the event edge: stall now, redirect next, idle after
  task automatic check_redirect(input string tag);
    logic [31:0] exp;
    check({tag, "_stall"}, stall_o, 1);
    check({tag, "_noredir"}, redirect_o, 0);
    step();
    check({tag, "_redir"}, redirect_o, 1);
    if (sb.size() == 0) begin
      n_total++;
      $error("FAIL %s_sb: observed empty queue expected entry", tag);
    end else begin
      exp = sb.pop_front();
      check({tag, "_target"}, target_pc_o, exp);
    end
    check({tag, "_stall_off"}, stall_o, 0);
    step();
    check({tag, "_redir_off"}, redirect_o, 0);
    check({tag, "_idle_stall"}, stall_o, 0);
  endtask

  initial begin
    logic [31:0] exp_mtval;
    rst_i       = 1'b1;
    pc_i        = '0;
    instr_i     = '0;
    irq_i       = 1'b0;
    csr_addr_i  = '0;
    csr_wdata_i = '0;
    idle_inputs();
    #12;
    rst_i = 1'b0;
    step();

    // Reset state
    read_csr("rst_mtvec", 12'h305, 32'h100);
    read_csr("rst_mstatus", 12'h300, 32'h0);
    read_csr("rst_mepc", 12'h341, 32'h0);
    read_csr("rst_mcause", 12'h342, 32'h0);
    read_csr("rst_mtval", 12'h343, 32'h0);
    check("rst_stall", stall_o, 0);
    check("rst_redirect", redirect_o, 0);
    check("rst_target", target_pc_o, 0);

    // Enable MIE, then ecall at 0x40
    write_csr(12'h300, 32'h8);
    check("mie_set", mie_o, 1);
    valid_i = 1'b1; exception_i = 2'b10; pc_i = 32'h40;
    sb.push_back(32'h100);
    step();
    idle_inputs();
    check_redirect("ecall");
    check("ecall_mepc", mepc_o, 32'h40);
    read_csr("ecall_mcause", 12'h342, 32'd11);
    read_csr("ecall_mstatus", 12'h300, 32'h80);
    check("ecall_mie", mie_o, 0);

    // Interrupt: pending while valid_i=0, taken once an instruction is valid
    write_csr(12'h300, 32'h8);
    irq_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("irq_wait_stall", stall_o, 0);
    end
    valid_i = 1'b1; pc_i = 32'h80;
    sb.push_back(32'h100);
    step();
    idle_inputs();
    check_redirect("irq");
    irq_i = 1'b0;
    check("irq_mepc", mepc_o, 32'h80);
    read_csr("irq_mcause", 12'h342, 32'h8000_000B);
    read_csr("irq_mstatus", 12'h300, 32'h80);

    // mret back to 0x80
    valid_i = 1'b1; is_mret_i = 1'b1; pc_i = 32'h90;
    sb.push_back(32'h80);
    step();
    idle_inputs();
    check_redirect("mret");
    read_csr("mret_mstatus", 12'h300, 32'h88);
    check("mret_mie", mie_o, 1);

    // irq that drops before any valid instruction: no trap
    irq_i = 1'b1;
    step(); step(); step();
    irq_i = 1'b0;
    step(); step(); step();
    valid_i = 1'b1; pc_i = 32'h200;
    step();
    idle_inputs();
    check("irq_drop_stall", stall_o, 0);
    step();
    check("irq_drop_redirect", redirect_o, 0);

    // Illegal + mret + mepc write in the same cycle: trap wins
    valid_i = 1'b1; exception_i = 2'b01; is_mret_i = 1'b1;
    pc_i = 32'h44; instr_i = 32'hDEAD_BEEF;
    csr_we_i = 1'b1; csr_addr_i = 12'h341; csr_wdata_i = 32'h1234;
    sb.push_back(32'h100);
    step();
    idle_inputs();
`ifdef TRAP_CTRL_MTVAL_EN
    exp_mtval = 32'hDEAD_BEEF;
`else
    exp_mtval = 32'h0;
`endif
    check("coll_mepc", mepc_o, 32'h44);
    read_csr("coll_mcause", 12'h342, 32'd2);
    read_csr("coll_mstatus", 12'h300, 32'h80);
    read_csr("coll_mtval", 12'h343, exp_mtval);
    check_redirect("coll");

    // CSR write masking and unmapped addresses
    write_csr(12'h341, 32'h1237);
    read_csr("mepc_mask", 12'h341, 32'h1234);
    write_csr(12'h344, 32'hFFFF_FFFF);
    read_csr("unmapped", 12'h344, 32'h0);
    write_csr(12'h305, 32'h203);
    read_csr("mtvec_mask", 12'h305, 32'h200);

    // ebreak redirects to the new mtvec
    valid_i = 1'b1; exception_i = 2'b11; pc_i = 32'h60;
    sb.push_back(32'h200);
    step();
    idle_inputs();
    check_redirect("ebreak");
    read_csr("ebreak_mcause", 12'h342, 32'd3);
    read_csr("ebreak_mtval", 12'h343, 32'h0);

    // Asynchronous reset while in TRAP: everything back, no redirect later
    valid_i = 1'b1; exception_i = 2'b10; pc_i = 32'h70;
    step();
    idle_inputs();
    check("rstmid_in_trap", stall_o, 1);
    #2;
    rst_i = 1'b1;
    #1;
    check("rstmid_stall", stall_o, 0);
    check("rstmid_redirect", redirect_o, 0);
    check("rstmid_target", target_pc_o, 0);
    check("rstmid_mepc", mepc_o, 0);
    read_csr("rstmid_mtvec", 12'h305, 32'h100);
    #2;
    rst_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rstmid_no_redirect", redirect_o, 0);
    end

    check("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Machine-mode trap sequencer in the EX stage, alongside the branch/jump resolver.
- Takes decoded exceptions, mret, and a synchronised external interrupt, then owns mepc/mcause/mstatus(MIE,MPIE)/mtvec.
- Sequences trap entry and return as a stall-then-redirect pair, so the PC mux and pipeline flush see one clean redirect pulse with its target address.

Parameters:
MTVEC_RESET, 32'h0000_0100, reset value of mtvec (bits [1:0] forced 0, direct mode only)
IRQ_SYNC_STAGES, 2, flip-flop stages on irq_i (legal 2..4)

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset; asynchronous, active-high
valid_i  input  1  EX-stage instruction valid
pc_i  input  32  EX-stage instruction PC
exception_i  input  2  00 none, 01 illegal instr, 10 ecall, 11 ebreak
is_mret_i  input  1  EX-stage instruction is mret
instr_i  input  32  EX-stage instruction bits (used only with the optional feature)
irq_i  input  1  asynchronous external interrupt, level
csr_we_i  input  1  CSR write strobe
csr_addr_i  input  12  CSR address for write and read
csr_wdata_i  input  32  CSR write data
csr_rdata_o  output  32  combinational CSR read data
stall_o  output  1  hold the front end (TRAP/RET state)
redirect_o  output  1  one-cycle PC redirect plus flush of younger stages
target_pc_o  output  32  redirect target, valid while redirect_o=1
mepc_o  output  32  current mepc
mie_o  output  1  current mstatus.MIE

Behaviour:
- Reset values (async): state IDLE; mepc=0; mcause=0; MIE=0; MPIE=0; mtvec=MTVEC_RESET; irq sync chain=0; stall_o=0; redirect_o=0; target_pc_o=0.
- irq_s is the output of the IRQ_SYNC_STAGES flop chain on irq_i.
- Events are evaluated in IDLE only, when valid_i=1. Priority: exception > interrupt (irq_s & MIE) > mret.
- Exception, IDLE->TRAP:
  - mepc<=pc_i.
  - mcause<=2 for illegal, 11 for ecall, 3 for ebreak.
  - MPIE<=MIE; MIE<=0.
- Interrupt, IDLE->TRAP:
  - mepc<=pc_i; the instruction does not retire.
  - mcause<=32'h8000_000B.
  - MPIE<=MIE; MIE<=0.
- mret, IDLE->RET: MIE<=MPIE; MPIE<=1.
- TRAP: stall_o=1; next state REDIR_T.
- RET: stall_o=1; next state REDIR_R.
- REDIR_T: redirect_o=1, target_pc_o={mtvec[31:2],2'b00}; next IDLE.
- REDIR_R: redirect_o=1, target_pc_o=mepc; next IDLE.
- Latency: event cycle N, stall at N+1, redirect at N+2, IDLE at N+3. Inputs are ignored outside IDLE.
- The redirect target always comes from registered state, never from same-cycle inputs.
- CSR map:
  - 0x300 mstatus: bit3 MIE, bit7 MPIE, other bits read 0.
  - 0x305 mtvec: bits[1:0] read 0.
  - 0x341 mepc: bits[1:0] written as 0.
  - 0x342 mcause.
  - Unmapped addresses read 0; writes to them are ignored.
- CSR writes take effect on the clock edge in any state.
- On a same-cycle collision, the trap/mret update wins for the fields it touches (mepc, mcause, MIE, MPIE); mtvec writes always apply.
- Reads return the pre-edge register value (no write bypass).
- valid_i=0 in IDLE: no event is taken; a pending interrupt waits.
- irq deasserted before being taken: no trap.
- Reset mid-sequence (TRAP/RET/REDIR_*): returns to IDLE and redirect is lost. This is intended; the pipeline also resets.
- exception_i plus is_mret_i in the same cycle: the exception is taken; mret has no effect on mstatus.

Optional Feature:
- Macro TRAP_CTRL_MTVAL_EN.
- Defined:
  - Adds 32-bit mtval at CSR 0x343, reset 0, writable.
  - On illegal-instruction trap, mtval<=instr_i.
  - On ecall, ebreak or interrupt, mtval<=0.
  - The trap update wins over a same-cycle CSR write.
- Undefined: no register; 0x343 reads 0, writes are ignored, instr_i is unused.

Decomposition:
- Shared package:
  - CSR addresses.
  - Exception code enum (EXC_NONE/ILLEGAL/ECALL/EBREAK).
  - mcause constants 2/3/11/0x8000000B.
  - mstatus bit indices MIE=3, MPIE=7.
  - FSM state encoding IDLE/TRAP/RET/REDIR_T/REDIR_R.
- Sub-module: sync_ff (parameterised depth, async active-high reset) for irq_i.

Test Plan:
- Reset, then read 0x305 -> 0x100. Read 0x300, 0x341, 0x342 -> 0. stall_o=0, redirect_o=0.
- ecall at pc 0x0000_0040 -> mepc=0x40, mcause=11, stall at N+1, redirect N+2 to 0x100, MIE cleared.
- Write mstatus=0x8 (MIE=1), hold irq_i=1 for 3 cycles with valid_i=1 at pc 0x80 -> mcause=0x8000000B, mepc=0x80, MPIE=1, MIE=0, redirect to mtvec.
- Then mret -> stall N+1, redirect N+2 to 0x80, MIE=1, MPIE=1.
- Illegal instruction plus is_mret_i, with a same-cycle CSR write mepc=0x1234 -> mcause=2, mepc=pc_i (trap wins); with TRAP_CTRL_MTVAL_EN, mtval=instr_i.
- rst_i pulsed asynchronously during TRAP -> all outputs at reset values immediately, no redirect afterwards.
